// File: rtl/waveform_pkt_pkg.sv
// Shared types and constants for the waveform packetizer.
// Holds the FSM state type, the default start marker and the packet length helper.
package waveform_pkt_pkg;

    localparam logic [7:0] HDR_BYTE_DEFAULT = 8'hA5;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_SEND_HDR,
        ST_SEND_SEQ,
        ST_SEND_PH_HI,
        ST_SEND_PH_LO,
        ST_SEND_SAMP_HI,
        ST_SEND_SAMP_LO,
        ST_SEND_CSUM
    } pkt_state_e;

    // HDR + SEQ + two pulse-height bytes + two bytes per sample + CSUM
    function automatic int pkt_len(input int nsamp);
        return 2 + 2 + 2 * nsamp + 1;
    endfunction

endpackage

// File: rtl/sample_buffer.sv
// Simple dual-port sample RAM: one synchronous write port, one registered read port.
// Latency: read data appears one cycle after the address. No backpressure.
// Backpressure: none; the caller holds rd_addr to hold rd_dat.
module sample_buffer #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 14
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_dat,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_dat
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_dat_q;

    // No reset so the array and read register map onto a block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_dat;
        end
        rd_dat_q <= mem_q[rd_addr];
    end

    assign rd_dat = rd_dat_q;

endmodule

// File: rtl/waveform_packetizer.sv
// Captures one gated ADC window and streams it as a framed, checksummed byte packet.
// Latency: HDR byte valid the cycle after the window is seen low; one byte per cycle thereafter.
// Backpressure: tx_ready stalls the stream with tx_data held; windows arriving while sending are dropped.
module waveform_packetizer
    import waveform_pkt_pkg::*;
#(
    parameter int         NSAMP    = 32,
    parameter int         SAMPW    = 14,
    parameter logic [7:0] HDR_BYTE = HDR_BYTE_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             window_in,
    input  logic [SAMPW-1:0] sample_in,
    input  logic [SAMPW-1:0] pulse_height_in,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             busy,
    output logic [7:0]       drop_count
);

    localparam int AW = $clog2(NSAMP);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(NSAMP);
    localparam logic [AW-1:0] IDX_LAST = AW'(NSAMP - 1);

    pkt_state_e       state_q, state_d;
    logic             window_q, window_d;
    logic [CW-1:0]    wr_cnt_q, wr_cnt_d;
    logic [AW-1:0]    samp_idx_q, samp_idx_d;
    logic [SAMPW-1:0] ph_q, ph_d;
    logic [7:0]       seq_q, seq_d;
    logic [7:0]       csum_q, csum_d;
    logic [7:0]       drop_q, drop_d;

    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [SAMPW-1:0] rd_dat;
    logic             sending;
    logic             rise;
    logic             xfer;
    logic [7:0]       tx_byte;
    logic [15:0]      ph_word;
    logic [15:0]      samp_word;

    assign sending = (state_q != ST_IDLE) && (state_q != ST_CAPTURE);
    assign rise    = window_in & ~window_q;
    assign xfer    = sending & tx_ready;
    assign ph_word = 16'(ph_q);
    // Addresses past the written count read back as zero instead of stale RAM contents.
    assign samp_word = (CW'(samp_idx_q) < wr_cnt_q) ? 16'(rd_dat) : 16'h0000;

    always_comb begin
        state_d    = state_q;
        window_d   = window_in;
        wr_cnt_d   = wr_cnt_q;
        samp_idx_d = samp_idx_q;
        ph_d       = ph_q;
        seq_d      = seq_q;
        csum_d     = csum_q;
        drop_d     = drop_q;
        wr_en      = 1'b0;
        wr_addr    = '0;
        tx_byte    = 8'h00;

        case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    state_d  = ST_CAPTURE;
                    wr_en    = 1'b1;
                    wr_addr  = '0;
                    wr_cnt_d = CW'(1);
                end
            end
            ST_CAPTURE: begin
                if (window_in) begin
                    if (wr_cnt_q < CNT_FULL) begin
                        wr_en    = 1'b1;
                        wr_addr  = wr_cnt_q[AW-1:0];
                        wr_cnt_d = wr_cnt_q + 1'b1;
                    end
                end else begin
                    ph_d       = pulse_height_in;
                    samp_idx_d = '0;
                    csum_d     = 8'h00;
                    state_d    = ST_SEND_HDR;
                end
            end
            ST_SEND_HDR: begin
                tx_byte = HDR_BYTE;
                if (xfer) state_d = ST_SEND_SEQ;
            end
            ST_SEND_SEQ: begin
                tx_byte = seq_q;
                if (xfer) state_d = ST_SEND_PH_HI;
            end
            ST_SEND_PH_HI: begin
                tx_byte = ph_word[15:8];
                if (xfer) state_d = ST_SEND_PH_LO;
            end
            ST_SEND_PH_LO: begin
                tx_byte = ph_word[7:0];
                if (xfer) state_d = ST_SEND_SAMP_HI;
            end
            ST_SEND_SAMP_HI: begin
                tx_byte = samp_word[15:8];
                if (xfer) state_d = ST_SEND_SAMP_LO;
            end
            ST_SEND_SAMP_LO: begin
                tx_byte = samp_word[7:0];
                if (xfer) begin
                    samp_idx_d = samp_idx_q + 1'b1;
                    state_d    = (samp_idx_q == IDX_LAST) ? ST_SEND_CSUM : ST_SEND_SAMP_HI;
                end
            end
            ST_SEND_CSUM: begin
                tx_byte = csum_q;
                if (xfer) begin
                    seq_d   = seq_q + 8'd1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (xfer && (state_q != ST_SEND_HDR) && (state_q != ST_SEND_CSUM)) begin
            csum_d = csum_q + tx_byte;
        end

        if (rise && sending && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            window_q   <= 1'b0;
            wr_cnt_q   <= '0;
            samp_idx_q <= '0;
            ph_q       <= '0;
            seq_q      <= 8'h00;
            csum_q     <= 8'h00;
            drop_q     <= 8'h00;
        end else begin
            state_q    <= state_d;
            window_q   <= window_d;
            wr_cnt_q   <= wr_cnt_d;
            samp_idx_q <= samp_idx_d;
            ph_q       <= ph_d;
            seq_q      <= seq_d;
            csum_q     <= csum_d;
            drop_q     <= drop_d;
        end
    end

    // Reading the next-cycle index keeps the RAM one step ahead, so SAMP_HI never waits on a read.
    sample_buffer #(
        .DEPTH (NSAMP),
        .WIDTH (SAMPW)
    ) u_buf (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_dat  (sample_in),
        .rd_addr (samp_idx_d),
        .rd_dat  (rd_dat)
    );

    assign tx_data    = tx_byte;
    assign tx_valid   = sending;
    assign busy       = (state_q != ST_IDLE);
    assign drop_count = drop_q;

endmodule
